// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush-to-bubble conversion
// and an optional bubble counter enabled by ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regwrite_d,
  input  logic [1:0]           resultsrc_d,
  input  logic                 memwrite_d,
  input  logic                 jump_d,
  input  logic                 branch_d,
  input  logic [2:0]           alucontrol_d,
  input  logic                 alusrc_d,
  input  logic [XLEN-1:0]      rd1_d,
  input  logic [XLEN-1:0]      rd2_d,
  input  logic [XLEN-1:0]      pc_d,
  input  logic [XLEN-1:0]      pcplus4_d,
  input  logic [XLEN-1:0]      immext_d,
  input  logic [REGADDR_W-1:0] rs1_d,
  input  logic [REGADDR_W-1:0] rs2_d,
  input  logic [REGADDR_W-1:0] rd_d,
  input  logic                 pcsrc_e,
  output logic                 regwrite_e,
  output logic [1:0]           resultsrc_e,
  output logic                 memwrite_e,
  output logic                 jump_e,
  output logic                 branch_e,
  output logic [2:0]           alucontrol_e,
  output logic                 alusrc_e,
  output logic [XLEN-1:0]      rd1_e,
  output logic [XLEN-1:0]      rd2_e,
  output logic [XLEN-1:0]      pc_e,
  output logic [XLEN-1:0]      pcplus4_e,
  output logic [XLEN-1:0]      immext_e,
  output logic [REGADDR_W-1:0] rs1_e,
  output logic [REGADDR_W-1:0] rs2_e,
  output logic [REGADDR_W-1:0] rd_e,
  output logic                 valid_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [CNT_W-1:0]     bubbles_o
);
  typedef struct packed {
    logic                 regwrite;
    logic [1:0]           resultsrc;
    logic                 memwrite;
    logic                 jump;
    logic                 branch;
    logic [2:0]           alucontrol;
    logic                 alusrc;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pcplus4;
    logic [XLEN-1:0]      immext;
    logic [REGADDR_W-1:0] rs1;
    logic [REGADDR_W-1:0] rs2;
    logic [REGADDR_W-1:0] rd;
    logic                 valid;
  } ex_t;
  ex_t ex_d, ex_q;
  logic lwstall;
  // A bubble is all-zero, so it can never look like a load and never stalls.
  assign lwstall = ex_q.valid && ex_q.resultsrc == 2'b01 && ex_q.rd != '0 &&
                   (ex_q.rd == rs1_d || ex_q.rd == rs2_d);
  assign stall_f = lwstall;
  assign stall_d = lwstall;
  assign flush_d = pcsrc_e;
  assign flush_e = lwstall | pcsrc_e;
  always_comb begin
    ex_d = flush_e ? '0 : ex_t'{regwrite: regwrite_d, resultsrc: resultsrc_d, memwrite: memwrite_d,
                                jump: jump_d, branch: branch_d, alucontrol: alucontrol_d,
                                alusrc: alusrc_d, rd1: rd1_d, rd2: rd2_d, pc: pc_d,
                                pcplus4: pcplus4_d, immext: immext_d, rs1: rs1_d, rs2: rs2_d,
                                rd: rd_d, valid: 1'b1};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else ex_q <= ex_d;
  end
  assign regwrite_e   = ex_q.regwrite;
  assign resultsrc_e  = ex_q.resultsrc;
  assign memwrite_e   = ex_q.memwrite;
  assign jump_e       = ex_q.jump;
  assign branch_e     = ex_q.branch;
  assign alucontrol_e = ex_q.alucontrol;
  assign alusrc_e     = ex_q.alusrc;
  assign rd1_e        = ex_q.rd1;
  assign rd2_e        = ex_q.rd2;
  assign pc_e         = ex_q.pc;
  assign pcplus4_e    = ex_q.pcplus4;
  assign immext_e     = ex_q.immext;
  assign rs1_e        = ex_q.rs1;
  assign rs2_e        = ex_q.rs2;
  assign rd_e         = ex_q.rd;
  assign valid_e      = ex_q.valid;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] bubbles_d, bubbles_q;
  always_comb bubbles_d = bubbles_q + CNT_W'(flush_e);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bubbles_q <= '0;
    else bubbles_q <= bubbles_d;
  end
  assign bubbles_o = bubbles_q;
`else
  assign bubbles_o = '0;
`endif
endmodule
